// File: rtl/nios_cpu_onchip_mem_tester.sv
// rtl/nios_cpu_onchip_mem_tester.sv - on-chip RAM self-test master: pattern write, pipelined read-back, compare
module nios_cpu_onchip_mem_tester #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4849,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  cfg_err,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;
    localparam int RL    = READ_LATENCY;
    localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d, count_q, count_d;
    logic [1:0]          drain_q, drain_d;
    logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0]   seed_q, seed_d, wdata_q, wdata_d;
    logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;
    logic                pass_q, pass_d, cfg_err_q, cfg_err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                pv_q [RL];
    logic                pv_d [RL];
    logic [DATA_W-1:0]   pe_q [RL];
    logic [DATA_W-1:0]   pe_d [RL];
    logic [ADDR_W-1:0]   pa_q [RL];
    logic [ADDR_W-1:0]   pa_d [RL];
    logic [ADDR_W+1:0]   end_addr;
    logic                mismatch;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        count_d          = count_q;
        drain_d          = drain_q;
        base_d           = base_q;
        seed_d           = seed_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        pass_d           = pass_q;
        cfg_err_d        = cfg_err_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        end_addr         = (ADDR_W+2)'(base_addr) + (ADDR_W+2)'(word_count);

        // Each read enters the tracking pipe with its expected word and address
        pv_d[0] = (state_q == S_READ);
        pe_d[0] = seed_q + DATA_W'(idx_q);
        pa_d[0] = addr_q;
        for (int j = 1; j < RL; j++) begin
            pv_d[j] = pv_q[j-1];
            pe_d[j] = pe_q[j-1];
            pa_d[j] = pa_q[j-1];
        end

        mismatch = pv_q[RL-1] && (m_readdata != pe_q[RL-1]);
        if (mismatch) begin
            if (err_count_q == 16'h0000) begin
                first_err_addr_d = pa_q[RL-1];
                first_err_data_d = m_readdata;
            end
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    base_d           = base_addr;
                    count_d          = word_count;
                    seed_d           = seed;
                    pass_d           = 1'b0;
                    cfg_err_d        = 1'b0;
                    err_count_d      = 16'h0000;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    idx_d            = '0;
                    drain_d          = 2'd0;
                    if (end_addr > DEPTH_L) begin
                        cfg_err_d = 1'b1;
                    end else if (word_count == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == count_q - CNT_W'(1)) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_READ: begin
                if (idx_q == count_q - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                    drain_d = 2'd0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'(RL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort discards anything still in flight, including this cycle's compare
        if (abort && state_q != S_IDLE) begin
            state_d          = S_IDLE;
            err_count_d      = err_count_q;
            first_err_addr_d = first_err_addr_q;
            first_err_data_d = first_err_data_q;
            for (int j = 0; j < RL; j++) begin
                pv_d[j] = 1'b0;
            end
        end

        if (state_d == S_WRITE || state_d == S_READ) begin
            addr_d = base_d + ADDR_W'(idx_d);
        end
        if (state_d == S_WRITE) begin
            wdata_d = seed_d + DATA_W'(idx_d);
        end
        if (state_d == S_DONE) begin
            pass_d = (err_count_d == 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            count_q          <= '0;
            drain_q          <= 2'd0;
            base_q           <= '0;
            seed_q           <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            pass_q           <= 1'b0;
            cfg_err_q        <= 1'b0;
            err_count_q      <= 16'h0000;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            for (int j = 0; j < RL; j++) begin
                pv_q[j] <= 1'b0;
                pe_q[j] <= '0;
                pa_q[j] <= '0;
            end
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            count_q          <= count_d;
            drain_q          <= drain_d;
            base_q           <= base_d;
            seed_q           <= seed_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            pass_q           <= pass_d;
            cfg_err_q        <= cfg_err_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            for (int j = 0; j < RL; j++) begin
                pv_q[j] <= pv_d[j];
                pe_q[j] <= pe_d[j];
                pa_q[j] <= pa_d[j];
            end
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign cfg_err        = cfg_err_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign m_address      = addr_q;
    assign m_writedata    = wdata_q;
    assign m_chipselect   = (state_q == S_WRITE) || (state_q == S_READ);
    assign m_write        = (state_q == S_WRITE);
    assign m_byteenable   = {BE_W{busy}};
    assign m_clken        = busy;

endmodule

// File: tb/tb_nios_cpu_onchip_mem_tester.sv
// tb/tb_nios_cpu_onchip_mem_tester.sv - bench for the RAM self-test master at read latencies 1, 2 and 3
module tb_nios_cpu_onchip_mem_tester;
    localparam int DEPTH = 4849;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [12:0] base_addr;
    logic [13:0] word_count;
    logic [31:0] seed;

    logic        busy_a   [3];
    logic        done_a   [3];
    logic        pass_a   [3];
    logic        cfg_a    [3];
    logic [15:0] errc_a   [3];
    logic [12:0] fea_a    [3];
    logic [31:0] fed_a    [3];
    logic [12:0] addr_a   [3];
    logic [3:0]  be_a     [3];
    logic        cs_a     [3];
    logic        we_a     [3];
    logic [31:0] wd_a     [3];
    logic        clken_a  [3];
    logic [31:0] rd_a     [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int cur_base = 0;
    int cur_count = 0;
    logic [31:0] cur_seed = 32'h0;
    int fault_mode = 0;
    int fault_addr = 0;

    int wr_n [3] = '{0, 0, 0};
    int rd_n [3] = '{0, 0, 0};
    int bad_n [3] = '{0, 0, 0};
    int cs_n [3] = '{0, 0, 0};
    int done_n [3] = '{0, 0, 0};
    int done_off [3] = '{0, 0, 0};
    logic done_pass [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] done_err [3] = '{16'h0, 16'h0, 16'h0};
    int mon_off;
    int mon_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] flip_of(input logic [12:0] a);
        return ((fault_mode == 2) || (fault_mode == 1 && int'(a) == fault_addr)) ? 32'h1 : 32'h0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int RL = g + 1;
        logic [31:0] mem [DEPTH];
        logic [31:0] pipe [3];

        always @(posedge clk) begin
            if (cs_a[g] && we_a[g] && int'(addr_a[g]) < DEPTH) mem[addr_a[g]] <= wd_a[g];
            if (cs_a[g] && !we_a[g] && int'(addr_a[g]) < DEPTH)
                pipe[0] <= mem[addr_a[g]] ^ flip_of(addr_a[g]);
            else
                pipe[0] <= 32'hDEADBEEF;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rd_a[g] = pipe[RL-1];

        nios_cpu_onchip_mem_tester #(
            .ADDR_W(13), .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(RL)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
            .base_addr(base_addr), .word_count(word_count), .seed(seed),
            .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]), .cfg_err(cfg_a[g]),
            .err_count(errc_a[g]), .first_err_addr(fea_a[g]), .first_err_data(fed_a[g]),
            .m_address(addr_a[g]), .m_byteenable(be_a[g]), .m_chipselect(cs_a[g]),
            .m_write(we_a[g]), .m_writedata(wd_a[g]), .m_clken(clken_a[g]),
            .m_readdata(rd_a[g])
        );
    end

    // Bus monitor: write k belongs on cycle 1+k, read k on cycle 1+count+k
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            mon_off = cyc - start_cyc;
            if (cs_a[g]) begin
                cs_n[g] = cs_n[g] + 1;
                if (we_a[g]) begin
                    mon_k = mon_off - 1;
                    wr_n[g] = wr_n[g] + 1;
                end else begin
                    mon_k = mon_off - 1 - cur_count;
                    rd_n[g] = rd_n[g] + 1;
                end
                if (mon_k < 0 || mon_k >= cur_count || int'(addr_a[g]) != cur_base + mon_k)
                    bad_n[g] = bad_n[g] + 1;
                else if (we_a[g] && wd_a[g] != cur_seed + 32'(mon_k))
                    bad_n[g] = bad_n[g] + 1;
                if (!busy_a[g]) bad_n[g] = bad_n[g] + 1;
            end
            if (busy_a[g] && (be_a[g] != 4'hF || !clken_a[g])) bad_n[g] = bad_n[g] + 1;
            if (!busy_a[g] && (be_a[g] != 4'h0 || clken_a[g])) bad_n[g] = bad_n[g] + 1;
            if (done_a[g]) begin
                done_n[g] = done_n[g] + 1;
                done_off[g] = mon_off;
                done_pass[g] = pass_a[g];
                done_err[g] = errc_a[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_run(input int base, input int cnt, input logic [31:0] sd,
                          input int fmode, input int faddr, input int poke_off, input int abort_off);
        int wr0 [3];
        int rd0 [3];
        int bad0 [3];
        int cs0 [3];
        int dn0 [3];
        int errs;
        int fa;
        logic [31:0] fd;
        logic exp_cfg;
        int total;
        string t;

        exp_cfg = (base + cnt > DEPTH);
        fault_mode = fmode;
        fault_addr = faddr;
        errs = 0;
        fa = 0;
        fd = 32'h0;
        for (int i = 0; i < cnt && !exp_cfg; i++) begin
            if (flip_of(13'(base + i)) != 32'h0) begin
                if (errs == 0) begin
                    fa = base + i;
                    fd = (sd + 32'(i)) ^ 32'h1;
                end
                errs++;
            end
        end
        if (errs > 65535) errs = 65535;

        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            wr0[g] = wr_n[g]; rd0[g] = rd_n[g]; bad0[g] = bad_n[g];
            cs0[g] = cs_n[g]; dn0[g] = done_n[g];
        end
        cur_base = base;
        cur_count = cnt;
        cur_seed = sd;
        base_addr = 13'(base);
        word_count = 14'(cnt);
        seed = sd;
        start = 1'b1;
        start_cyc = cyc;
        total = exp_cfg ? 6 : 2 * cnt + 8;
        for (int off = 1; off <= total; off++) begin
            @(negedge clk);
            if (off == 1) start = 1'b0;
            if (off == poke_off) begin
                start = 1'b1;
                base_addr = 13'(base + 100);
            end
            if (off == poke_off + 1) begin
                start = 1'b0;
                base_addr = 13'(base);
            end
            if (off == abort_off) abort = 1'b1;
            if (abort_off >= 0 && off == abort_off + 1) begin
                abort = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    chk($sformatf("abort_busy_next[rl%0d]", g + 1), busy_a[g], 1'b0);
                    chk($sformatf("abort_cs_next[rl%0d]", g + 1), cs_a[g], 1'b0);
                end
            end
        end

        for (int g = 0; g < 3; g++) begin
            t = $sformatf("b%0h_c%0d_rl%0d", base, cnt, g + 1);
            chk({t, "_bus"}, bad_n[g] - bad0[g], 0);
            chk({t, "_busy_end"}, busy_a[g], 1'b0);
            if (exp_cfg) begin
                chk({t, "_cfg_err"}, cfg_a[g], 1'b1);
                chk({t, "_cfg_no_cs"}, cs_n[g] - cs0[g], 0);
                chk({t, "_cfg_no_done"}, done_n[g] - dn0[g], 0);
            end else if (abort_off >= 0) begin
                chk({t, "_abort_no_done"}, done_n[g] - dn0[g], 0);
                chk({t, "_abort_pass"}, pass_a[g], 1'b0);
                chk({t, "_abort_errs"}, errc_a[g], 16'(0));
            end else begin
                chk({t, "_cfg_err"}, cfg_a[g], 1'b0);
                chk({t, "_writes"}, wr_n[g] - wr0[g], cnt);
                chk({t, "_reads"}, rd_n[g] - rd0[g], cnt);
                chk({t, "_done_n"}, done_n[g] - dn0[g], 1);
                chk({t, "_done_off"}, done_off[g], 2 * cnt + (g + 1) + 1);
                chk({t, "_pass_at_done"}, done_pass[g], errs == 0);
                chk({t, "_errs"}, done_err[g], 16'(errs));
                chk({t, "_pass_held"}, pass_a[g], errs == 0);
                if (errs > 0) begin
                    chk({t, "_first_addr"}, fea_a[g], 13'(fa));
                    chk({t, "_first_data"}, fed_a[g], fd);
                end
            end
        end
        fault_mode = 0;
    endtask

    initial begin
        int b, c, r, fm, fa;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        word_count = '0;
        seed = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_busy", busy_a[g], 1'b0);
            chk("rst_done", done_a[g], 1'b0);
            chk("rst_pass", pass_a[g], 1'b0);
            chk("rst_cfg", cfg_a[g], 1'b0);
            chk("rst_cs", cs_a[g], 1'b0);
            chk("rst_we", we_a[g], 1'b0);
            chk("rst_clken", clken_a[g], 1'b0);
            chk("rst_be", be_a[g], 4'h0);
            chk("rst_err", errc_a[g], 16'h0);
            chk("rst_addr", addr_a[g], 13'h0);
            chk("rst_wd", wd_a[g], 32'h0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(16'h010, 4, 32'h10000000, 0, 0, -1, -1);
        do_run(16'h010, 4, 32'h10000000, 1, 16'h012, -1, -1);
        do_run(16'h12F0, 2, 32'h0BADF00D, 0, 0, -1, -1);
        do_run(16'h12F0, 1, 32'h0BADF00D, 0, 0, -1, -1);
        do_run(16'h0040, 0, 32'h12345678, 0, 0, -1, -1);
        do_run(16'h0100, 3, 32'hFFFFFFFE, 0, 0, -1, -1);
        do_run(16'h0100, 8, 32'hA5A50000, 0, 0, -1, 10);
        do_run(16'h0200, 6, 32'h00C0FFEE, 0, 0, 3, -1);

        for (int n = 0; n < 12; n++) begin
            r = $urandom_range(0, 5);
            if (r == 0) begin
                b = $urandom_range(DEPTH - 20, 8191);
                c = ((DEPTH - b + 1) > 1 ? (DEPTH - b + 1) : 1) + $urandom_range(0, 30);
            end else begin
                c = $urandom_range(0, 24);
                b = $urandom_range(0, DEPTH - c);
            end
            fm = $urandom_range(0, 2);
            fa = b + $urandom_range(0, (c > 0) ? c - 1 : 0);
            do_run(b, c, $urandom, fm, fa, -1, -1);
        end

        // Asynchronous reset in the middle of the write phase
        @(negedge clk);
        cur_base = 16'h040; cur_count = 10; cur_seed = 32'h55AA0000;
        base_addr = 13'h040; word_count = 14'd10; seed = 32'h55AA0000;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("midrst_busy", busy_a[g], 1'b0);
            chk("midrst_cs", cs_a[g], 1'b0);
            chk("midrst_we", we_a[g], 1'b0);
            chk("midrst_clken", clken_a[g], 1'b0);
            chk("midrst_be", be_a[g], 4'h0);
            chk("midrst_addr", addr_a[g], 13'h0);
            chk("midrst_wd", wd_a[g], 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("postrst_busy", busy_a[g], 1'b0);

        do_run(0, DEPTH, 32'h600DCAFE, 2, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nios_cpu_onchip_mem_tester.md
Name: nios_cpu_onchip_mem_tester

Overview:
- Avalon-MM master that drives the on-chip RAM slave port (address/byteenable/chipselect/write/writedata/clken; readdata at fixed read latency, no waitrequest).
- On start, writes a deterministic pattern over a programmed word range, reads the range back pipelined, compares, and reports pass/fail, error count and first failing location.
- Used for power-on RAM self-test and bench bring-up, arbitrated in front of the RAM slave while the CPU is held off.

Parameters:
- ADDR_W, 13, word address width of the RAM port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 4849, number of implemented words; highest legal address is DEPTH-1
- READ_LATENCY, 1, cycles from read address presented to m_readdata valid (1 to 3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  stop the test at the next clock edge
- base_addr  in  ADDR_W  first word address, latched on start
- word_count  in  ADDR_W+1  number of words, latched on start
- seed  in  DATA_W  pattern seed, latched on start
- busy  out  1  high from the cycle after start is accepted until completion
- done  out  1  one-cycle pulse on completion; not pulsed on abort or config error
- pass  out  1  valid once done has pulsed; held until the next accepted start
- cfg_err  out  1  range illegal; set instead of running
- err_count  out  16  count of mismatching words; saturates at 0xFFFF
- first_err_addr  out  ADDR_W  address of the first mismatch
- first_err_data  out  DATA_W  data read at the first mismatch
- m_address  out  ADDR_W  RAM word address
- m_byteenable  out  DATA_W/8  always all ones while busy
- m_chipselect  out  1  RAM access strobe
- m_write  out  1  write qualifier
- m_writedata  out  DATA_W  write data
- m_clken  out  1  RAM clock enable; high while busy
- m_readdata  in  DATA_W  RAM read data

Behaviour:
- Reset, asynchronous: state IDLE. busy, done, pass, cfg_err, m_chipselect, m_write and m_clken are 0. err_count, first_err_addr, first_err_data, m_address and m_writedata are 0. m_byteenable is 0.
- Pattern:
  - Word i (0-based) expects seed + i, modulo 2^DATA_W.
  - The address for word i is base_addr + i.
  - Addresses never wrap.
- Accepting start in IDLE:
  - Latch the inputs and clear pass, cfg_err, err_count, first_err_addr and first_err_data.
  - If word_count==0: go to DONE; pass=1 and done pulses 2 cycles after start.
  - If base_addr+word_count > DEPTH: set cfg_err, return to IDLE, no bus access, no done pulse.
- States:
  - IDLE -> WRITE on accepted start.
  - WRITE: for word_count cycles, assert chipselect=1, write=1, one word per cycle in ascending address order. Then go to READ.
  - READ: for word_count cycles, assert chipselect=1, write=0, one address per cycle.
  - DRAIN: READ_LATENCY cycles, chipselect=0, while the last reads return.
  - DONE: one cycle, done=1, pass=(err_count==0). Then go to IDLE.
- Compare pipeline:
  - A READ_LATENCY-deep shift register of valid bit, expected data and address tracks each read.
  - m_readdata is compared when the valid bit emerges.
  - On a mismatch, err_count increments (saturating).
  - On the first mismatch only, first_err_addr and first_err_data are captured.
- Timing: done asserts exactly 2*word_count + READ_LATENCY + 1 cycles after the start-sampling edge.
- busy is low in IDLE and high in all other states.
- abort, highest priority, any non-IDLE state:
  - Next edge: IDLE with chipselect/write low.
  - No done pulse; pass stays 0.
  - err_count keeps the value reached so far.
  - In-flight compare results are discarded.
- start while busy is ignored. start together with abort in IDLE: abort wins and start is ignored.
- Bus outputs are deasserted (chipselect=0, write=0) in IDLE, DRAIN and DONE.

Test Plan:
- Nominal run, RAM model READ_LATENCY=1. base=0x010, count=4, seed=0x10000000.
  - Writes to 0x010..0x013 carry data 0x10000000..0x10000003 on cycles 1-4.
  - Reads of 0x010..0x013 occur on cycles 5-8.
  - done pulses on cycle 10 with pass=1 and err_count=0.
- Fault injection: same run, but the model flips bit 0 of the word at 0x012 on read.
  - err_count=1, first_err_addr=0x012, first_err_data=0x10000003, pass=0.
- Range checks:
  - base=0x12F0, count=0x0002 (end 0x12F2 > 4849): cfg_err=1, no chipselect ever, no done.
  - base=0x12F0, count=0x0001: runs and passes.
- Edge cases:
  - count=0: done 2 cycles after start, pass=1, no bus access.
  - seed=0xFFFFFFFE, count=3: expected data is 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, and pass=1.
- Abort and start handling:
  - abort during READ: the next cycle has busy=0 and chipselect=0, and done never pulses.
  - start while busy is ignored.
  - reset_n low mid-WRITE clears all outputs immediately.
- Full-depth run with every word faulted, DEPTH=4849: err_count=4849.
  - Also run READ_LATENCY=2 and 3 models and check done timing against the formula.
